// File: rtl/vga_channel_bars.sv
// VGA bar renderer for NCH signed channels: pixel-enable timing, tear-free shadow->display commit at vblank.
// Optional build macro PEAK_HOLD_EN adds per-channel decaying peak-hold markers.
module vga_channel_bars #(
  parameter int NCH        = 3,
  parameter int DW         = 8,
  parameter int CLK_DIV    = 2,
  parameter int H_ACT      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYN      = 96,
  parameter int H_BP       = 48,
  parameter int V_ACT      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYN      = 2,
  parameter int V_BP       = 33,
  parameter int BAR_Y0     = 40,
  parameter int BAR_H      = 32,
  parameter int BAR_PITCH  = 64,
  parameter int BAR_SCALE  = 1,
  parameter int PEAK_DECAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              ch_valid,
  output logic [2:0]        pixel,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_tick
);

  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int XW    = $clog2(H_TOT);
  localparam int YW    = $clog2(V_TOT);
  localparam int DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int C     = H_ACT / 2;

  logic [DIVW-1:0]       div_p0;
  logic                  pix_ce;
  logic [XW-1:0]         x_p0;
  logic [YW-1:0]         y_p0;
  logic                  commit_p0;
  logic [31:0]           xi;
  logic [31:0]           yi;
  logic [2:0]            pix_nxt;
  logic                  hs_nxt;
  logic                  vs_nxt;
  logic [2:0]            pixel_p1;
  logic                  hsync_p1;
  logic                  vsync_p1;
  logic                  frame_tick_p1;
  logic signed [DW-1:0]  shadow  [NCH];
  logic signed [DW-1:0]  display [NCH];
  logic [DW-1:0]         peak_v  [NCH];

  // Magnitude in DW+1 bits so the most negative sample does not overflow.
  function automatic logic [DW:0] mag(input logic signed [DW-1:0] v);
    logic [DW:0] w;
    w = {v[DW-1], v};
    return v[DW-1] ? (~w + 1'b1) : w;
  endfunction

  function automatic logic [DW-1:0] sat_dec(input logic [DW-1:0] pk);
    return (32'(pk) > PEAK_DECAY) ? (pk - DW'(PEAK_DECAY)) : '0;
  endfunction

  function automatic logic [2:0] band_pixel(input int idx, input logic [31:0] xv,
                                            input logic signed [DW-1:0] v, input logic [DW-1:0] pk);
    logic [31:0] len;
    logic [31:0] mk;
    logic [2:0]  col;
    len = 32'(mag(v)) * BAR_SCALE;
    mk  = 32'(pk) * BAR_SCALE;
    col = 3'((idx % 7) + 1);
    band_pixel = 3'b000;
    if (v > 0 && xv > C && (xv - C) <= len)
      band_pixel = col;
    if (v < 0 && xv < C && (C - xv) <= len)
      band_pixel = col;
    if (xv == C)
      band_pixel = 3'b111;
    if (pk != '0 && (xv == C + mk || (mk <= C && xv == C - mk)))
      band_pixel = 3'b111;
  endfunction

  assign pix_ce    = (div_p0 == DIVW'(CLK_DIV - 1));
  assign commit_p0 = pix_ce && (x_p0 == '0) && (y_p0 == YW'(V_ACT));

  // Stage p0 -> p1: render from the current counter position.
  always_comb begin
    pix_nxt = 3'b000;
    xi      = 32'(x_p0);
    yi      = 32'(y_p0);
    hs_nxt  = !(xi >= H_ACT + H_FP && xi < H_ACT + H_FP + H_SYN);
    vs_nxt  = !(yi >= V_ACT + V_FP && yi < V_ACT + V_FP + V_SYN);
    for (int i = NCH - 1; i >= 0; i--) begin
      if (xi < H_ACT && yi < V_ACT &&
          yi >= BAR_Y0 + i * BAR_PITCH && yi < BAR_Y0 + i * BAR_PITCH + BAR_H)
        pix_nxt = band_pixel(i, xi, display[i], peak_v[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_p0        <= '0;
      x_p0          <= '0;
      y_p0          <= '0;
      pixel_p1      <= 3'b000;
      hsync_p1      <= 1'b1;
      vsync_p1      <= 1'b1;
      frame_tick_p1 <= 1'b0;
    end else begin
      div_p0        <= pix_ce ? '0 : div_p0 + 1'b1;
      frame_tick_p1 <= commit_p0;
      if (pix_ce) begin
        if (x_p0 == XW'(H_TOT - 1)) begin
          x_p0 <= '0;
          y_p0 <= (y_p0 == YW'(V_TOT - 1)) ? '0 : y_p0 + 1'b1;
        end else begin
          x_p0 <= x_p0 + 1'b1;
        end
        pixel_p1 <= pix_nxt;
        hsync_p1 <= hs_nxt;
        vsync_p1 <= vs_nxt;
      end
    end
  end

  // Commit reads the shadow before this edge's capture, so a colliding strobe lands next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i]  <= '0;
        display[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (commit_p0)
          display[i] <= shadow[i];
        if (ch_valid)
          shadow[i] <= ch_data[i*DW +: DW];
      end
    end
  end

`ifdef PEAK_HOLD_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++)
        peak_v[i] <= '0;
    end else if (commit_p0) begin
      for (int i = 0; i < NCH; i++)
        peak_v[i] <= (mag(shadow[i]) > (DW+1)'(sat_dec(peak_v[i]))) ?
                     DW'(mag(shadow[i])) : sat_dec(peak_v[i]);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NCH; i++)
      peak_v[i] = '0;
  end
`endif

  assign pixel      = pixel_p1;
  assign hsync_out  = hsync_p1;
  assign vsync_out  = vsync_p1;
  assign frame_tick = frame_tick_p1;

endmodule

// File: tb/tb_vga_channel_bars.sv
// Scoreboard bench for vga_channel_bars on a reduced raster; expected outputs come from a cycle-index model.
module tb_vga_channel_bars;

  localparam int NCH = 4, DW = 5, CLK_DIV = 2;
  localparam int H_ACT = 48, H_FP = 2, H_SYN = 4, H_BP = 2;
  localparam int V_ACT = 36, V_FP = 1, V_SYN = 2, V_BP = 1;
  localparam int BAR_Y0 = 4, BAR_H = 6, BAR_PITCH = 10, BAR_SCALE = 2, PEAK_DECAY = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int FRAME_PIX = H_TOT * V_TOT;
  localparam int FRAME_CLK = FRAME_PIX * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] ch_data;
  logic              ch_valid;
  logic [2:0]        pixel;
  logic              hsync_out, vsync_out, frame_tick;

  int checks = 0;
  int errors = 0;

  vga_channel_bars #(
    .NCH(NCH), .DW(DW), .CLK_DIV(CLK_DIV),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP),
    .BAR_Y0(BAR_Y0), .BAR_H(BAR_H), .BAR_PITCH(BAR_PITCH),
    .BAR_SCALE(BAR_SCALE), .PEAK_DECAY(PEAK_DECAY)
  ) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .pixel(pixel), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model state: edges since reset, shadow/display values, peaks.
  int unsigned k = 0;
  bit          seen_rst = 1'b0;
  int          m_shadow [NCH];
  int          m_disp   [NCH];
  int          m_peak   [NCH];
  logic [5:0]  cur_exp;
  logic [5:0]  exp_q [$];

  function automatic bit is_commit_edge(input int unsigned kk);
    if (kk < CLK_DIV || kk % CLK_DIV != 0) return 1'b0;
    return ((kk / CLK_DIV - 1) % FRAME_PIX) == V_ACT * H_TOT;
  endfunction

  function automatic logic [2:0] ref_pixel(input int x, input int y);
    int c, v, len, mk, top;
    c = H_ACT / 2;
    if (x >= H_ACT || y >= V_ACT) return 3'b000;
    for (int i = 0; i < NCH; i++) begin
      top = BAR_Y0 + i * BAR_PITCH;
      if (y >= top && y < top + BAR_H) begin
        v   = m_disp[i];
        len = (v < 0 ? -v : v) * BAR_SCALE;
        mk  = m_peak[i] * BAR_SCALE;
        if (mk > 0 && (x == c + mk || x == c - mk)) return 3'b111;
        if (x == c) return 3'b111;
        if (v > 0 && x >= c + 1 && x <= c + len) return 3'((i % 7) + 1);
        if (v < 0 && x <= c - 1 && x >= c - len) return 3'((i % 7) + 1);
        return 3'b000;
      end
    end
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    int p, x, y, a, d;
    if (rst === 1'b0) begin
      seen_rst = 1'b1;
      k = 0;
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = 0; m_disp[i] = 0; m_peak[i] = 0;
      end
      cur_exp = {1'b0, 1'b1, 1'b1, 3'b000};
    end else if (seen_rst) begin
      k++;
      cur_exp[5] = 1'b0;
      if (k % CLK_DIV == 0) begin
        p = int'(k / CLK_DIV) - 1;
        x = p % H_TOT;
        y = (p / H_TOT) % V_TOT;
        cur_exp[2:0] = ref_pixel(x, y);
        cur_exp[4]   = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYN);
        cur_exp[3]   = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYN);
        if (is_commit_edge(k)) begin
          cur_exp[5] = 1'b1;
          for (int i = 0; i < NCH; i++) begin
            m_disp[i] = m_shadow[i];
`ifdef PEAK_HOLD_EN
            a = m_shadow[i] < 0 ? -m_shadow[i] : m_shadow[i];
            d = m_peak[i] - PEAK_DECAY;
            if (d < 0) d = 0;
            m_peak[i] = (a > d) ? a : d;
`endif
          end
        end
      end
      if (ch_valid === 1'b1)
        for (int i = 0; i < NCH; i++)
          m_shadow[i] = int'($signed(ch_data[i*DW +: DW]));
    end
    if (seen_rst) exp_q.push_back(cur_exp);
  end

  always @(negedge clk) begin
    logic [5:0] e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {frame_tick, hsync_out, vsync_out, pixel};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs edge=%0d {tick,hs,vs,pix} got=%b required=%b", k, got, e);
      end
    end
  end

  function automatic logic [NCH*DW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    logic [NCH*DW-1:0] r;
    r[0*DW +: DW] = DW'(a0);
    r[1*DW +: DW] = DW'(a1);
    r[2*DW +: DW] = DW'(a2);
    r[3*DW +: DW] = DW'(a3);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [NCH*DW-1:0] d);
    ch_data  = d;
    ch_valid = 1'b1;
    @(negedge clk);
    ch_valid = 1'b0;
  endtask

  task automatic wait_commit();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!is_commit_edge(k) && guard < 2 * FRAME_CLK);
    checks++;
    if (guard >= 2 * FRAME_CLK) begin
      errors++;
      $display("FAIL commit_wait cycles=%0d required<%0d", guard, 2 * FRAME_CLK);
    end
  endtask

  task automatic strobe_on_commit(input logic [NCH*DW-1:0] d);
    int guard = 0;
    while (!is_commit_edge(k + 1) && guard < 2 * FRAME_CLK) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 2 * FRAME_CLK) begin
      errors++;
      $display("FAIL collision_wait cycles=%0d required<%0d", guard, 2 * FRAME_CLK);
    end
    strobe(d);
  endtask

  initial begin
    rst = 1'b0; ch_valid = 1'b0; ch_data = '0;
    idle(3);
    rst = 1'b1;
    // Directed bar shapes, each displayed for one full frame.
    strobe(pack(10, -5, 0, 7));
    wait_commit();
    strobe(pack(-16, 15, -1, -16));
    wait_commit();
    // Collision: mid-frame sample commits, colliding sample waits one frame.
    strobe(pack(3, 3, 3, 3));
    strobe_on_commit(pack(15, -16, 5, 0));
    wait_commit();
    wait_commit();
    // Randomised frames with 0..3 strobes each (last one wins).
    for (int f = 0; f < 3; f++) begin
      int n = $urandom_range(0, 3);
      for (int s = 0; s < n; s++) begin
        idle($urandom_range(1, 1000));
        strobe(($urandom() << 10) ^ $urandom());
      end
      wait_commit();
    end
    // Mid-line reset for one clock.
    idle($urandom_range(50, 1500));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(20);
    strobe(pack(int'($urandom_range(0, 31)), -7, 12, 9));
    wait_commit();
    idle(FRAME_CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
